// File: rtl/alu_sequencer.sv
// Request-side sequencer for the 5-bit ALU datapath: accepts an operation, strobes the
// ALU input/output registers in order and returns the captured result on a response channel.
module alu_sequencer #(
    parameter int WIDTH       = 5,
    parameter int OP_W        = 3,
    parameter int NUM_OPS     = 6,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [OP_W-1:0]  req_op,
    output logic [WIDTH-1:0] a_data,
    output logic [WIDTH-1:0] b_data,
    output logic [OP_W-1:0]  op_sel,
    output logic             load,
    output logic             enable,
    input  logic             alu_carry,
    input  logic [WIDTH-1:0] res_reg,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_carry,
    output logic             resp_err,
    output logic             busy,
    output logic [7:0]       op_count,
    output logic [2:0]       dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        EXEC    = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } state_t;

    localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [OP_W-1:0]  op_q;
    logic [3:0]       cnt_q;
    logic             load_q;
    logic             enable_q;
    logic             resp_valid_q;
    logic             resp_carry_q;
    logic             resp_err_q;
    logic [7:0]       count_q;
    logic             op_legal;

    assign op_legal = ({1'b0, req_op} < (OP_W + 1)'(NUM_OPS));

    // Both channels: a transfer happens on a posedge where valid and ready are both high;
    // the sender holds its payload stable from raising valid until that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            cnt_q        <= '0;
            load_q       <= 1'b0;
            enable_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_carry_q <= 1'b0;
            resp_err_q   <= 1'b0;
            count_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        a_q  <= req_a;
                        b_q  <= req_b;
                        op_q <= req_op;
                        if (op_legal) begin
                            state_q <= LOAD;
                            load_q  <= 1'b1;
                        end else begin
                            // Illegal opcodes never touch the ALU registers.
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_carry_q <= 1'b0;
                        end
                    end
                end
                LOAD: begin
                    load_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= EXEC;
                end
                EXEC: begin
                    if (cnt_q == EXEC_LAST) begin
                        state_q  <= CAPTURE;
                        enable_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                CAPTURE: begin
                    enable_q     <= 1'b0;
                    resp_carry_q <= alu_carry;
                    resp_err_q   <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_carry_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        count_q      <= count_q + 8'd1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign a_data      = a_q;
    assign b_data      = b_q;
    assign op_sel      = op_q;
    assign load        = load_q;
    assign enable      = enable_q;
    assign resp_valid  = resp_valid_q;
    assign resp_carry  = resp_carry_q;
    assign resp_err    = resp_err_q;
    assign op_count    = count_q;
    assign dbg_state_o = state_q;

    // The output register captured on the edge that entered RESP, so res_reg is current here.
    assign resp_data = (resp_valid_q && !resp_err_q) ? res_reg : '0;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: instance 0 at the default settle time, instance 1 with
// EXEC_CYCLES=3; each instance drives a small behavioural ALU (input regs, output reg).
module tb_alu_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       req_valid[2], req_ready[2], load[2], enable[2], alu_carry[2];
    logic       resp_valid[2], resp_ready[2], resp_carry[2], resp_err[2], busy[2];
    logic [4:0] req_a[2], req_b[2], a_data[2], b_data[2], res_reg[2], resp_data[2];
    logic [2:0] req_op[2], op_sel[2], dbg_state[2];
    logic [7:0] op_count[2];

    int total = 0;
    int bad = 0;
    logic [7:0] exp_cnt;

    logic [4:0] got_d;
    logic       got_c, got_e;
    int         lat, ld_at, en_at, ld_n, en_n;

    alu_sequencer u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_a(req_a[0]), .req_b(req_b[0]), .req_op(req_op[0]),
        .a_data(a_data[0]), .b_data(b_data[0]), .op_sel(op_sel[0]),
        .load(load[0]), .enable(enable[0]),
        .alu_carry(alu_carry[0]), .res_reg(res_reg[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_data(resp_data[0]), .resp_carry(resp_carry[0]), .resp_err(resp_err[0]),
        .busy(busy[0]), .op_count(op_count[0]), .dbg_state_o(dbg_state[0])
    );

    alu_sequencer #(.EXEC_CYCLES(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_a(req_a[1]), .req_b(req_b[1]), .req_op(req_op[1]),
        .a_data(a_data[1]), .b_data(b_data[1]), .op_sel(op_sel[1]),
        .load(load[1]), .enable(enable[1]),
        .alu_carry(alu_carry[1]), .res_reg(res_reg[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_data(resp_data[1]), .resp_carry(resp_carry[1]), .resp_err(resp_err[1]),
        .busy(busy[1]), .op_count(op_count[1]), .dbg_state_o(dbg_state[1])
    );

    // ALU: 0 add, 1 sub (borrow in carry), 2 and, 3 or, 4 xor, 5 not A.
    function automatic logic [5:0] alu_f(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b);
        case (op)
            3'd0:    alu_f = {1'b0, a} + {1'b0, b};
            3'd1:    alu_f = {1'b0, a} - {1'b0, b};
            3'd2:    alu_f = {1'b0, a & b};
            3'd3:    alu_f = {1'b0, a | b};
            3'd4:    alu_f = {1'b0, a ^ b};
            default: alu_f = {1'b0, ~a};
        endcase
    endfunction

    logic [4:0] ra[2], rb[2];
    logic [2:0] rop[2];
    logic [5:0] alu_out[2];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            alu_out[k]   = alu_f(rop[k], ra[k], rb[k]);
            alu_carry[k] = alu_out[k][5];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                ra[k] <= '0; rb[k] <= '0; rop[k] <= '0; res_reg[k] <= '0;
            end else begin
                if (load[k]) begin
                    ra[k] <= a_data[k]; rb[k] <= b_data[k]; rop[k] <= op_sel[k];
                end
                if (enable[k]) res_reg[k] <= alu_out[k][4:0];
            end
        end
    end

    // Present a request at a negedge, wait for ready, return just after the accept edge.
    task automatic issue(input int s, input logic [4:0] a, input logic [4:0] b, input logic [2:0] op);
        int g = 0;
        @(negedge clk);
        req_a[s] = a; req_b[s] = b; req_op[s] = op; req_valid[s] = 1'b1;
        while (!req_ready[s] && g < 50) begin
            @(negedge clk);
            g++;
        end
        total++;
        if (req_ready[s] !== 1'b1) begin
            bad++;
            $display("FAIL accept_timeout inst=%0d req_ready=%b exp=1", s, req_ready[s]);
        end
        @(posedge clk);
    endtask

    // Observe each cycle after accept (n=0 is the cycle started by the accept edge).
    task automatic collect(input int s);
        lat = -1; ld_at = -1; en_at = -1; ld_n = 0; en_n = 0;
        got_d = '0; got_c = 1'b0; got_e = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n == 0) req_valid[s] = 1'b0;
            if (load[s]) begin ld_n++; ld_at = n; end
            if (enable[s]) begin en_n++; en_at = n; end
            if (resp_valid[s]) begin
                lat = n; got_d = resp_data[s]; got_c = resp_carry[s]; got_e = resp_err[s];
                break;
            end
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0; req_a[s] = '0; req_b[s] = '0; req_op[s] = '0; resp_ready[s] = 1'b1;
        end
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (load[0] !== 1'b0) begin bad++; $display("FAIL rst_load got=%b exp=0", load[0]); end
        total++; if (enable[0] !== 1'b0) begin bad++; $display("FAIL rst_enable got=%b exp=0", enable[0]); end
        total++; if (resp_valid[0] !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid[0]); end
        total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy[0]); end
        total++; if (op_count[0] !== 8'd0) begin bad++; $display("FAIL rst_op_count got=%0d exp=0", op_count[0]); end
        total++; if ({a_data[0], b_data[0], op_sel[0]} !== 13'd0) begin bad++; $display("FAIL rst_datapath got=%h exp=0", {a_data[0], b_data[0], op_sel[0]}); end
        total++; if ({resp_err[0], resp_carry[0]} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b exp=00", {resp_err[0], resp_carry[0]}); end
        total++; if (req_ready[0] !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b exp=1", req_ready[0]); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (dbg_state[0] !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", dbg_state[0]); end
        exp_cnt = 8'd0;
    endtask

    task automatic test_add();
        issue(0, 5'd7, 5'd9, 3'd0);
        collect(0);
        total++; if (lat !== 3) begin bad++; $display("FAIL add_latency got=%0d exp=3", lat); end
        total++; if (got_d !== 5'd16) begin bad++; $display("FAIL add_data got=%0d exp=16", got_d); end
        total++; if ({got_c, got_e} !== 2'b00) begin bad++; $display("FAIL add_flags got=%b exp=00", {got_c, got_e}); end
        total++; if (ld_at !== 0 || ld_n !== 1) begin bad++; $display("FAIL add_load at=%0d n=%0d exp at=0 n=1", ld_at, ld_n); end
        total++; if (en_at !== 2 || en_n !== 1) begin bad++; $display("FAIL add_enable at=%0d n=%0d exp at=2 n=1", en_at, en_n); end
        @(negedge clk);
        exp_cnt = exp_cnt + 8'd1;
        total++; if (op_count[0] !== exp_cnt) begin bad++; $display("FAIL add_op_count got=%0d exp=%0d", op_count[0], exp_cnt); end
        total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL add_idle_busy got=%b exp=0", busy[0]); end
    endtask

    task automatic test_ops();
        logic [4:0] ta[7] = '{5'd31, 5'd5, 5'd20, 5'd12, 5'd12, 5'd12, 5'd5};
        logic [4:0] tb[7] = '{5'd1, 5'd9, 5'd6, 5'd10, 5'd10, 5'd10, 5'd0};
        logic [2:0] to[7] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        logic [4:0] td[7] = '{5'd0, 5'd28, 5'd14, 5'd8, 5'd14, 5'd6, 5'd26};
        logic       tc[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            issue(0, ta[i], tb[i], to[i]);
            collect(0);
            exp_cnt = exp_cnt + 8'd1;
            total++;
            if (lat !== 3 || got_d !== td[i] || got_c !== tc[i] || got_e !== 1'b0) begin
                bad++;
                $display("FAIL op_vec%0d lat=%0d d=%0d c=%b e=%b exp lat=3 d=%0d c=%b e=0", i, lat, got_d, got_c, got_e, td[i], tc[i]);
            end
        end
        @(negedge clk);
        total++; if (op_count[0] !== exp_cnt) begin bad++; $display("FAIL ops_op_count got=%0d exp=%0d", op_count[0], exp_cnt); end
    endtask

    task automatic test_illegal();
        logic [2:0] ops[2] = '{3'd7, 3'd6};
        for (int i = 0; i < 2; i++) begin
            issue(0, 5'd3, 5'd4, ops[i]);
            collect(0);
            exp_cnt = exp_cnt + 8'd1;
            total++;
            if (lat !== 0 || got_e !== 1'b1 || got_d !== 5'd0 || got_c !== 1'b0 || ld_n !== 0 || en_n !== 0) begin
                bad++;
                $display("FAIL illegal_op%0d lat=%0d e=%b d=%0d c=%b ld=%0d en=%0d exp lat=0 e=1 d=0 c=0 ld=0 en=0", ops[i], lat, got_e, got_d, got_c, ld_n, en_n);
            end
        end
        @(negedge clk);
        total++; if (op_count[0] !== exp_cnt) begin bad++; $display("FAIL illegal_op_count got=%0d exp=%0d", op_count[0], exp_cnt); end
    endtask

    task automatic test_backpressure();
        int stall_bad = 0;
        resp_ready[0] = 1'b0;
        issue(0, 5'd3, 5'd4, 3'd0);
        collect(0);
        total++; if (lat !== 3 || got_d !== 5'd7) begin bad++; $display("FAIL bp_first lat=%0d d=%0d exp lat=3 d=7", lat, got_d); end
        req_a[0] = 5'd12; req_b[0] = 5'd10; req_op[0] = 3'd2; req_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid[0] !== 1'b1 || resp_data[0] !== 5'd7 || resp_carry[0] !== 1'b0 ||
                resp_err[0] !== 1'b0 || req_ready[0] !== 1'b0 || op_count[0] !== exp_cnt)
                stall_bad++;
        end
        total++; if (stall_bad != 0) begin bad++; $display("FAIL bp_stall_stable bad_cycles=%0d exp=0", stall_bad); end
        resp_ready[0] = 1'b1;
        issue(0, 5'd12, 5'd10, 3'd2);
        collect(0);
        total++; if (lat !== 3 || got_d !== 5'd8) begin bad++; $display("FAIL bp_pending lat=%0d d=%0d exp lat=3 d=8", lat, got_d); end
        @(negedge clk);
        exp_cnt = exp_cnt + 8'd2;
        total++; if (op_count[0] !== exp_cnt) begin bad++; $display("FAIL bp_op_count got=%0d exp=%0d", op_count[0], exp_cnt); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        issue(0, 5'd7, 5'd9, 3'd0);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        total++; if (busy[0] !== 1'b1 || dbg_state[0] !== 3'd2) begin bad++; $display("FAIL mid_in_exec busy=%b state=%0d exp busy=1 state=2", busy[0], dbg_state[0]); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (load[0] !== 1'b0 || enable[0] !== 1'b0 || busy[0] !== 1'b0 || resp_valid[0] !== 1'b0 || op_count[0] !== 8'd0) begin
            bad++;
            $display("FAIL mid_async_reset load=%b en=%b busy=%b rv=%b cnt=%0d exp all 0", load[0], enable[0], busy[0], resp_valid[0], op_count[0]);
        end
        exp_cnt = 8'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid[0] !== 1'b0 || load[0] !== 1'b0 || enable[0] !== 1'b0) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL mid_no_response cycles=%0d exp=0", seen); end
        issue(0, 5'd5, 5'd10, 3'd3);
        collect(0);
        total++; if (lat !== 3 || got_d !== 5'd15 || got_c !== 1'b0) begin bad++; $display("FAIL mid_fresh lat=%0d d=%0d c=%b exp lat=3 d=15 c=0", lat, got_d, got_c); end
        @(negedge clk);
        exp_cnt = exp_cnt + 8'd1;
        total++; if (op_count[0] !== exp_cnt) begin bad++; $display("FAIL mid_op_count got=%0d exp=%0d", op_count[0], exp_cnt); end
    endtask

    task automatic test_back_to_back();
        int cnt = 0;
        int last = -1;
        int bad_sp = 0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 8'd0;
        req_a[0] = 5'd1; req_b[0] = 5'd2; req_op[0] = 3'd0; req_valid[0] = 1'b1; resp_ready[0] = 1'b1;
        for (int cyc = 0; cyc < 2000 && cnt < 256; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (req_ready[0]) begin
                if (cnt == 255) begin
                    total++; if (op_count[0] !== 8'd255) begin bad++; $display("FAIL b2b_count_255 got=%0d exp=255", op_count[0]); end
                end
                if (last >= 0 && cyc - last != 5) bad_sp++;
                last = cyc;
                cnt++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        repeat (6) @(negedge clk);
        total++; if (cnt != 256) begin bad++; $display("FAIL b2b_accepts got=%0d exp=256", cnt); end
        total++; if (bad_sp != 0) begin bad++; $display("FAIL b2b_spacing bad_gaps=%0d exp=0", bad_sp); end
        total++; if (op_count[0] !== 8'd0) begin bad++; $display("FAIL b2b_wrap got=%0d exp=0", op_count[0]); end
    endtask

    task automatic test_sweep();
        issue(1, 5'd20, 5'd15, 3'd0);
        collect(1);
        total++; if (lat !== 5) begin bad++; $display("FAIL sweep_latency got=%0d exp=5", lat); end
        total++; if (ld_at !== 0 || en_at !== 4 || en_n !== 1) begin bad++; $display("FAIL sweep_strobes ld_at=%0d en_at=%0d en_n=%0d exp 0 4 1", ld_at, en_at, en_n); end
        total++; if (got_d !== 5'd3 || got_c !== 1'b1) begin bad++; $display("FAIL sweep_result d=%0d c=%b exp d=3 c=1", got_d, got_c); end
        issue(1, 5'd1, 5'd1, 3'd7);
        collect(1);
        total++; if (lat !== 0 || got_e !== 1'b1 || ld_n !== 0) begin bad++; $display("FAIL sweep_illegal lat=%0d e=%b ld=%0d exp 0 1 0", lat, got_e, ld_n); end
        @(negedge clk);
        total++; if (op_count[1] !== 8'd2) begin bad++; $display("FAIL sweep_op_count got=%0d exp=2", op_count[1]); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ops();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
